psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator.sv | 143 ++++++++++++++
 tb/tb_psum_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Sums N signed PE psum lanes per element, saturates, and writes one output row to the global buffer.
// Optional macro PSUM_ACCUMULATOR_RELU_EN clamps negative results to zero after saturation.
module psum_accumulator #(
    parameter int N                        = 3,
    parameter int DATA_WIDTH               = 16,
    parameter int GLOBAL_BUFFER_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH                = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Start,
    input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]                out_len,
    input  logic [N*DATA_WIDTH-1:0]             psum_data,
    input  logic [N-1:0]                        psum_valid,
    output logic [N-1:0]                        psum_ready,
    output logic                                gb_wr_en,
    output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gb_wr_addr,
    output logic [DATA_WIDTH-1:0]               gb_wr_data,
    output logic                                Done,
    output logic [1:0]                          state_dbg
);

    // Headroom so the sum of N full-scale lanes can never wrap before saturation.
    localparam int SUM_W = DATA_WIDTH + $clog2(N) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]                len_q;
    logic [LEN_WIDTH-1:0]                count;
    logic [LEN_WIDTH-1:0]                count_inc;
    logic                                handshake;
    logic                                last_elem;
    logic signed [SUM_W-1:0]             lane_sum;
    logic [DATA_WIDTH-1:0]               sat_data;
    logic [DATA_WIDTH-1:0]               result;

    // Handshake: all lanes are consumed together on an edge where state==COLLECT and every
    // psum_valid bit is high; psum_ready mirrors that condition combinationally on all lanes.
    assign handshake = (state == COLLECT) && (&psum_valid);
    assign count_inc = count + LEN_WIDTH'(1);
    assign last_elem = (count_inc == len_q);
    assign state_dbg = state;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < N; i++) begin
            lane_sum = lane_sum + SUM_W'($signed(psum_data[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_comb begin
        if (lane_sum > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (lane_sum < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_data = lane_sum[DATA_WIDTH-1:0];
        end
    end

`ifdef PSUM_ACCUMULATOR_RELU_EN
    assign result = sat_data[DATA_WIDTH-1] ? '0 : sat_data;
`else
    assign result = sat_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = (out_len != '0) ? COLLECT : FINISH;
                end
            end
            COLLECT: begin
                if (handshake) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_elem ? FINISH : COLLECT;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        psum_ready = {N{handshake}};
        gb_wr_en   = (state == WRITE);
        Done       = (state == FINISH);
    end

    // Write address/data are captured at the handshake so they hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            count      <= '0;
            gb_wr_addr <= '0;
            gb_wr_data <= '0;
        end else begin
            if (state == IDLE && Start) begin
                base_q <= base_addr;
                len_q  <= out_len;
                count  <= '0;
            end
            if (handshake) begin
                gb_wr_addr <= base_q + GLOBAL_BUFFER_ADDR_WIDTH'(count);
                gb_wr_data <= result;
            end
            if (state == WRITE) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table of lane triples, scoreboard of expected writes.
module tb_psum_accumulator;

  localparam int W = 26;  // {addr[9:0], data[15:0]}

  typedef struct {
    int          a;
    int          b;
    int          c;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  base_addr;
  logic [3:0]  out_len;
  logic [47:0] psum_data;
  logic [2:0]  psum_valid;
  logic [2:0]  psum_ready;
  logic        gb_wr_en;
  logic [9:0]  gb_wr_addr;
  logic [15:0] gb_wr_data;
  logic        Done;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_wr;
  vec_t         vecs[20];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_seen = 0;
  int           rows_done = 0;

  psum_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .base_addr  (base_addr),
    .out_len    (out_len),
    .psum_data  (psum_data),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .gb_wr_en   (gb_wr_en),
    .gb_wr_addr (gb_wr_addr),
    .gb_wr_data (gb_wr_data),
    .Done       (Done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] relu_fix(input int v);
`ifdef PSUM_ACCUMULATOR_RELU_EN
    if (v < 0) return 16'd0;
`endif
    return 16'(v);
  endfunction

  // Reference: exact integer sum, clamp to 16-bit signed range, optional ReLU.
  function automatic logic [15:0] model(input int a, input int b, input int c);
    int s;
    s = a + b + c;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return relu_fix(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr,data}; idle cycles must hold the last write.
  always @(negedge clk) begin
    if (rst) begin
      last_wr = '0;
    end else begin
      if (gb_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", gb_wr_addr, gb_wr_data);
        end else begin
          last_wr = exp_q.pop_front();
          check("wr_addr", 32'(gb_wr_addr), 32'(last_wr[25:16]));
          check("wr_data", 32'(gb_wr_data), 32'(last_wr[15:0]));
        end
      end else begin
        check("hold_addr", 32'(gb_wr_addr), 32'(last_wr[25:16]));
        check("hold_data", 32'(gb_wr_data), 32'(last_wr[15:0]));
      end
      if (Done) done_seen++;
    end
  end

  task automatic start_row(input logic [9:0] base, input int len);
    Start     = 1'b1;
    base_addr = base;
    out_len   = 4'(len);
    @(negedge clk);
    Start     = 1'b0;
    base_addr = $urandom_range(0, 1023);
    out_len   = 4'($urandom_range(0, 15));
  endtask

  // Called at a negedge in COLLECT; returns at the negedge after the write cycle.
  task automatic elem(input logic [9:0] addr, input vec_t v, input int stall);
    int w;
    psum_data = {16'(v.c), 16'(v.b), 16'(v.a)};
    for (int s = 0; s < stall; s++) begin
      psum_valid = 3'b011;
      #1;
      check("stall_ready", 32'(psum_ready), 32'd0);
      check("stall_no_write", 32'(gb_wr_en), 32'd0);
      @(negedge clk);
    end
    psum_valid = 3'b111;
    #1;
    w = 0;
    while (psum_ready !== 3'b111 && w < 8) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("handshake_ready", 32'(psum_ready), 32'h7);
    exp_q.push_back({addr, v.exp});
    @(posedge clk);
    @(negedge clk);
    check("wr_latency", 32'(gb_wr_en), 32'd1);
    check("ready_in_write", 32'(psum_ready), 32'd0);
    @(negedge clk);
    psum_valid = 3'b000;
  endtask

  task automatic run_row(input logic [9:0] base, input int first, input int len,
                         input int stall_idx, input int stall_n, input bit poke_start);
    start_row(base, len);
    if (poke_start) begin
      Start     = 1'b1;
      base_addr = 10'd7;
      out_len   = 4'd1;
      @(negedge clk);
      Start     = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      elem(base + 10'(i), vecs[first+i], (i == stall_idx) ? stall_n : 0);
      if (i < len - 1) check("no_early_done", 32'(Done), 32'd0);
    end
    check("done_pulse", 32'(Done), 32'd1);
    check("no_write_in_finish", 32'(gb_wr_en), 32'd0);
    @(negedge clk);
    check("done_single", 32'(Done), 32'd0);
    check("idle_after_done", 32'(state_dbg), 32'd0);
    rows_done++;
  endtask

  initial begin
    vecs[0]  = '{1, 2, 3, relu_fix(6)};
    vecs[1]  = '{4, 5, 6, relu_fix(15)};
    vecs[2]  = '{-1, -1, -1, relu_fix(-3)};
    vecs[3]  = '{32767, 32767, 1, relu_fix(32767)};
    vecs[4]  = '{-32768, -1, 0, relu_fix(-32768)};
    vecs[5]  = '{-32768, -32768, -32768, relu_fix(-32768)};
    vecs[6]  = '{32767, -32768, 0, relu_fix(-1)};
    vecs[7]  = '{100, -50, -49, relu_fix(1)};
    vecs[8]  = '{10000, 10000, 10000, relu_fix(30000)};
    vecs[9]  = '{20000, 20000, -7000, relu_fix(32767)};
    vecs[10] = '{-20000, -20000, 7000, relu_fix(-32768)};
    vecs[11] = '{0, 0, 0, relu_fix(0)};
    for (int i = 12; i < 20; i++) begin
      vecs[i].a   = int'($urandom_range(0, 65535)) - 32768;
      vecs[i].b   = int'($urandom_range(0, 65535)) - 32768;
      vecs[i].c   = int'($urandom_range(0, 65535)) - 32768;
      vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].c);
    end

    // Clock/reset
    rst        = 1'b1;
    Start      = 1'b0;
    base_addr  = '0;
    out_len    = '0;
    psum_data  = '0;
    psum_valid = '0;
    #3;
    check("rst_wr_en", 32'(gb_wr_en), 32'd0);
    check("rst_wr_addr", 32'(gb_wr_addr), 32'd0);
    check("rst_wr_data", 32'(gb_wr_data), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    run_row(10'd100, 0, 3, -1, 0, 1'b0);   // 6, 15, -3 at 100..102
    run_row(10'd1023, 3, 2, -1, 0, 1'b0);  // wraps to address 0
    run_row(10'd500, 5, 7, 0, 5, 1'b0);    // lane 2 stalls 5 cycles on first element
    run_row(10'd300, 7, 2, -1, 0, 1'b1);   // Start while busy is ignored
    run_row(10'd50, 0, 0, -1, 0, 1'b0);    // empty row: Done only
    run_row(10'd1021, 12, 4, 2, 2, 1'b0);
    run_row(10'($urandom_range(0, 1023)), 16, 4, 1, 1, 1'b0);

    // Reset in the middle of a 4-element row, after its first write.
    start_row(10'd200, 4);
    elem(10'd200, vecs[0], 0);
    psum_data  = {16'd9, 16'd9, 16'd9};
    psum_valid = 3'b111;
    #1;
    check("pre_rst_ready", 32'(psum_ready), 32'h7);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(psum_ready), 32'd0);
    check("async_rst_wr_en", 32'(gb_wr_en), 32'd0);
    check("async_rst_addr", 32'(gb_wr_addr), 32'd0);
    check("async_rst_data", 32'(gb_wr_data), 32'd0);
    check("async_rst_done", 32'(Done), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_done_after_rst", 32'(done_seen), 32'(rows_done));
    check("idle_after_rst", 32'(state_dbg), 32'd0);
    psum_valid = 3'b000;
    run_row(10'd400, 7, 1, -1, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(rows_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
